// File: rtl/dmem_bus_bridge_pkg.sv
// Shared types and constants for the data-memory to system-bus bridge.
// Holds the FSM state encoding, the bus word width and the zero word.
package dmem_bus_bridge_pkg;

  localparam int REG_BUS = 32;
  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // The bus only sees word addresses; the byte offset travels in the strobes.
  function automatic logic [REG_BUS-1:0] word_addr(input logic [REG_BUS-1:0] a);
    return {a[REG_BUS-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_bus_bridge_if.sv
// Request/response system-bus channel between the bridge (master) and a slave.
// Handshake: a request transfers on a rising edge where bus_req_valid and bus_req_ready are both 1;
// bus_req_* stays constant while valid is high; bus_rsp_valid is a one-cycle ack qualifying rdata/err.
interface dmem_bus_bridge_if;
  import dmem_bus_bridge_pkg::*;

  logic               bus_req_valid;
  logic               bus_req_ready;
  logic               bus_req_we;
  logic [REG_BUS-1:0] bus_req_addr;
  logic [REG_BUS-1:0] bus_req_wdata;
  logic [3:0]         bus_req_wstrb;
  logic               bus_rsp_valid;
  logic [REG_BUS-1:0] bus_rsp_rdata;
  logic               bus_rsp_err;

  modport master (
    output bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_wstrb,
    input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
  );

  modport slave (
    input  bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_wstrb,
    output bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
  );

endinterface

// File: rtl/dmem_bus_bridge_bus_timeout_cnt.sv
// Cycle counter bounding how long one bus access may stay outstanding.
// o_hit fires in the cycle whose increment would make the count reach LIMIT.
module bus_timeout_cnt #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_hit
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= 8'd0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_hit = i_enable && (r_cnt == LIMIT - 8'd1);

endmodule

// File: rtl/dmem_bus_bridge.sv
// Bridges the core's stall-based data-memory port onto a valid/ready request bus
// with a one-cycle response, a timeout abort and a held read-data register.
module dmem_bus_bridge
  import dmem_bus_bridge_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_BUS-1:0] addr,
  input  logic [REG_BUS-1:0] w_data,
  input  logic [3:0]         wen,
  input  logic               ren,
  output logic [REG_BUS-1:0] r_data,
  output logic               stall,
  output logic               err,
  output state_e             o_dbg_state,
  dmem_bus_bridge_if.master  bus
);

  state_e             r_state;
  state_e             w_next;
  logic               r_req_valid;
  logic               r_req_we;
  logic [REG_BUS-1:0] r_req_addr;
  logic [REG_BUS-1:0] r_req_wdata;
  logic [3:0]         r_req_wstrb;
  logic [REG_BUS-1:0] r_rdata;
  logic               r_err;

  logic w_access;
  logic w_is_write;
  logic w_clear;
  logic w_enable;
  logic w_hit;
  logic w_rsp_done;

  assign w_is_write = (wen != 4'b0000);
  assign w_access   = ren | w_is_write;

  bus_timeout_cnt #(
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_enable (w_enable),
    .o_hit    (w_hit)
  );

  // The timeout wins over a same-cycle ready or response: the access is aborted.
  always_comb begin
    w_next     = r_state;
    w_clear    = 1'b0;
    w_enable   = (r_state == ST_REQ) || (r_state == ST_WAIT);
    w_rsp_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          w_next  = ST_REQ;
          w_clear = 1'b1;
        end
      end
      ST_REQ: begin
        if (w_hit) begin
          w_next = ST_DONE;
        end else if (bus.bus_req_ready) begin
          w_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_hit) begin
          w_next = ST_DONE;
        end else if (bus.bus_rsp_valid) begin
          w_next     = ST_DONE;
          w_rsp_done = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_req_valid <= 1'b0;
      r_req_we    <= 1'b0;
      r_req_addr  <= ZERO_WORD;
      r_req_wdata <= ZERO_WORD;
      r_req_wstrb <= 4'b0000;
      r_rdata     <= ZERO_WORD;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_req_valid <= (w_next == ST_REQ);
      r_err       <= 1'b0;
      if ((r_state == ST_IDLE) && w_access) begin
        r_req_we    <= w_is_write;
        r_req_addr  <= word_addr(addr);
        r_req_wdata <= w_data;
        r_req_wstrb <= w_is_write ? wen : 4'b0000;
      end
      if (w_hit) begin
        r_err <= 1'b1;
        if (!r_req_we) r_rdata <= ZERO_WORD;
      end else if (w_rsp_done) begin
        r_err <= bus.bus_rsp_err;
        if (!r_req_we) r_rdata <= bus.bus_rsp_rdata;
      end
    end
  end

  assign stall = !rst && (((r_state == ST_IDLE) && w_access) ||
                          (r_state == ST_REQ) || (r_state == ST_WAIT));

  assign r_data      = r_rdata;
  assign err         = r_err;
  assign o_dbg_state = r_state;

  assign bus.bus_req_valid = r_req_valid;
  assign bus.bus_req_we    = r_req_we;
  assign bus.bus_req_addr  = r_req_addr;
  assign bus.bus_req_wdata = r_req_wdata;
  assign bus.bus_req_wstrb = r_req_wstrb;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Bench for dmem_bus_bridge: a core driver plus a delay-programmable bus slave,
// checked against an access-level model (cycle counts, request fields, read data).
module tb_dmem_bus_bridge;
  import dmem_bus_bridge_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] w_data;
  logic [3:0]  wen;
  logic        ren;
  logic [31:0] r_data;
  logic        stall;
  logic        err;
  state_e      dbg_state;

  dmem_bus_bridge_if bus ();

  dmem_bus_bridge #(.TIMEOUT(8'(TMO))) dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .w_data      (w_data),
    .wen         (wen),
    .ren         (ren),
    .r_data      (r_data),
    .stall       (stall),
    .err         (err),
    .o_dbg_state (dbg_state),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_rdata = '0;
  logic [68:0] exp_q[$];

  // One core access against a slave that raises ready after rdly valid cycles and
  // answers after rspdly wait cycles. The model: the access needs rdly+rspdly+2 bus
  // cycles and aborts once TMO bus cycles have been spent.
  task automatic run_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                            input logic re, input int rdly, input int rspdly, input logic rerr,
                            input logic [31:0] rdat, input bit gap);
    bit          is_wr, tmo, done, req_seen, pend;
    int          n, exp_stall, exp_valid, stall_cnt, valid_cnt, wait_cnt, cyc;
    logic        exp_err, obs_err, obs_valid;
    logic [68:0] obs, expv;
    logic [31:0] obs_rdata;
    state_e      obs_state;
    is_wr = (we != 4'b0000);
    n = rdly + rspdly + 2;
    tmo = (n >= TMO);
    exp_stall = 1 + (tmo ? TMO : n);
    exp_valid = (rdly + 1 < TMO) ? rdly + 1 : TMO;
    exp_err = tmo | rerr;
    if (rdly + 1 < TMO) exp_q.push_back({is_wr, a[31:2], 2'b00, (is_wr ? we : 4'b0000), wd});
    if (!is_wr) exp_rdata = tmo ? 32'h0 : rdat;
    done = 0; req_seen = 0; pend = 0; stall_cnt = 0; valid_cnt = 0; wait_cnt = 0; cyc = 0;
    obs = '0; obs_err = 1'b0; obs_valid = 1'b0; obs_rdata = '0; obs_state = ST_IDLE;
    @(posedge clk); #1;
    addr = a; w_data = wd; wen = we; ren = re;
    bus.bus_req_ready = 1'b0; bus.bus_rsp_valid = 1'b0; bus.bus_rsp_err = 1'b0; bus.bus_rsp_rdata = '0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (pend) begin
        pend = 0;
        if (stall) begin
          req_seen = 1;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL req_unexpected: got request %0h, required none", obs);
          end else begin
            expv = exp_q.pop_front();
            if (obs !== expv) begin
              failures++;
              $display("FAIL req_fields: got %0h required %0h", obs, expv);
            end
          end
        end
      end
      if (!stall) begin
        done = 1;
        obs_err = err; obs_rdata = r_data; obs_state = dbg_state; obs_valid = bus.bus_req_valid;
        bus.bus_req_ready = 1'b0; bus.bus_rsp_valid = 1'b0;
      end else begin
        stall_cnt++;
        bus.bus_req_ready = 1'b0; bus.bus_rsp_valid = 1'b0;
        if (bus.bus_req_valid) begin
          valid_cnt++;
          if (valid_cnt > rdly) begin
            bus.bus_req_ready = 1'b1;
            pend = 1;
            obs = {bus.bus_req_we, bus.bus_req_addr, bus.bus_req_wstrb, bus.bus_req_wdata};
          end
        end else if (req_seen) begin
          wait_cnt++;
          if (wait_cnt > rspdly) begin
            bus.bus_rsp_valid = 1'b1; bus.bus_rsp_err = rerr; bus.bus_rsp_rdata = rdat;
          end
        end
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL access_budget: stall still high after %0d cycles, required completion", cyc);
    end
    checks++;
    if (stall_cnt != exp_stall) begin
      failures++;
      $display("FAIL stall_cycles: got %0d required %0d", stall_cnt, exp_stall);
    end
    checks++;
    if (valid_cnt != exp_valid) begin
      failures++;
      $display("FAIL valid_cycles: got %0d required %0d", valid_cnt, exp_valid);
    end
    checks++;
    if (obs_err !== exp_err) begin
      failures++;
      $display("FAIL done_err: got %0b required %0b", obs_err, exp_err);
    end
    checks++;
    if (obs_rdata !== exp_rdata) begin
      failures++;
      $display("FAIL done_rdata: got %0h required %0h", obs_rdata, exp_rdata);
    end
    checks++;
    if (obs_state !== ST_DONE || obs_valid !== 1'b0) begin
      failures++;
      $display("FAIL done_state: got state %0d valid %0b required state %0d valid 0",
               obs_state, obs_valid, ST_DONE);
    end
    if (gap) begin
      // A stray response in IDLE must not disturb err or r_data.
      @(posedge clk); #1;
      ren = 1'b0; wen = 4'b0000;
      bus.bus_rsp_valid = 1'b1; bus.bus_rsp_err = 1'b1; bus.bus_rsp_rdata = $urandom;
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || stall !== 1'b0 || dbg_state !== ST_IDLE) begin
        failures++;
        $display("FAIL after_done: got err %0b stall %0b state %0d required 0 0 %0d",
                 err, stall, dbg_state, ST_IDLE);
      end
      bus.bus_rsp_valid = 1'b0; bus.bus_rsp_err = 1'b0;
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || r_data !== exp_rdata) begin
        failures++;
        $display("FAIL idle_hold: got err %0b rdata %0h required 0 %0h", err, r_data, exp_rdata);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; addr = $urandom; w_data = $urandom; wen = 4'hf; ren = 1'b1;
    bus.bus_req_ready = 1'b0; bus.bus_rsp_valid = 1'b0; bus.bus_rsp_err = 1'b0; bus.bus_rsp_rdata = '0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (stall !== 1'b0) begin
        failures++;
        $display("FAIL reset_stall: got %0b required 0", stall);
      end
    end
    checks++;
    if (bus.bus_req_valid !== 1'b0 || err !== 1'b0 || r_data !== 32'h0 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_outputs: got valid %0b err %0b rdata %0h state %0d required 0 0 0 %0d",
               bus.bus_req_valid, err, r_data, dbg_state, ST_IDLE);
    end
    checks++;
    if (bus.bus_req_addr !== 32'h0 || bus.bus_req_wdata !== 32'h0 || bus.bus_req_wstrb !== 4'h0) begin
      failures++;
      $display("FAIL reset_req_regs: got addr %0h wdata %0h wstrb %0h required 0 0 0",
               bus.bus_req_addr, bus.bus_req_wdata, bus.bus_req_wstrb);
    end
    rst = 1'b0; wen = 4'h0; ren = 1'b0;
    exp_rdata = '0;
  endtask

  task automatic test_directed();
    run_access(32'h0000_1004, 32'h0, 4'b0000, 1'b1, 0, 0, 1'b0, 32'hA5A5_1234, 1'b1);
    run_access(32'h0000_2002, 32'h0011_0000, 4'b0100, 1'b0, 5, 0, 1'b0, 32'h5555_AAAA, 1'b1);
    run_access(32'h0000_3008, 32'h0, 4'b0000, 1'b1, 1, 2, 1'b1, 32'h1357_9BDF, 1'b1);
  endtask

  task automatic test_timeout();
    run_access(32'h0000_4000, 32'h0, 4'b0000, 1'b1, 100, 0, 1'b0, 32'hFFFF_FFFF, 1'b1);
    run_access(32'h0000_5004, 32'h0, 4'b0000, 1'b1, 0, 0, 1'b0, 32'h2468_ACE0, 1'b1);
    run_access(32'h0000_6000, 32'hCAFE_F00D, 4'b0011, 1'b0, 2, 20, 1'b0, 32'h0, 1'b1);
    run_access(32'h0000_7000, 32'h0, 4'b0000, 1'b1, 2, 10, 1'b0, 32'h1111_2222, 1'b1);
  endtask

  task automatic test_read_write_collision();
    run_access(32'h0000_8001, 32'h8765_4321, 4'b1111, 1'b1, 0, 1, 1'b0, 32'hBAD0_BAD0, 1'b1);
  endtask

  task automatic test_reset_mid_wait();
    run_access(32'h0000_9000, 32'h0, 4'b0000, 1'b1, 0, 0, 1'b0, 32'h7777_8888, 1'b1);
    @(posedge clk); #1;
    addr = 32'h0000_A000; ren = 1'b1; wen = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    bus.bus_req_ready = bus.bus_req_valid;
    @(negedge clk);
    bus.bus_req_ready = 1'b0;
    checks++;
    if (dbg_state !== ST_WAIT) begin
      failures++;
      $display("FAIL rst_setup_wait: got state %0d required %0d", dbg_state, ST_WAIT);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || dbg_state !== ST_IDLE || bus.bus_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_abandon: got stall %0b state %0d valid %0b required 0 %0d 0",
               stall, dbg_state, bus.bus_req_valid, ST_IDLE);
    end
    rst = 1'b0; ren = 1'b0;
    exp_rdata = '0;
    @(negedge clk);
    bus.bus_rsp_valid = 1'b1; bus.bus_rsp_err = 1'b1; bus.bus_rsp_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.bus_rsp_valid = 1'b0; bus.bus_rsp_err = 1'b0;
    repeat (2) begin
      checks++;
      if (dbg_state !== ST_IDLE || err !== 1'b0 || r_data !== exp_rdata || stall !== 1'b0) begin
        failures++;
        $display("FAIL rst_late_rsp: got state %0d err %0b rdata %0h stall %0b required %0d 0 %0h 0",
                 dbg_state, err, r_data, stall, ST_IDLE, exp_rdata);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int          kind, rdly, rspdly;
    logic [3:0]  we;
    logic        re;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      re = (kind != 1);
      we = (kind == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      rdly = ($urandom_range(0, 9) == 0) ? 30 : $urandom_range(0, 4);
      rspdly = $urandom_range(0, 4);
      run_access($urandom, $urandom, we, re, rdly, rspdly, ($urandom_range(0, 3) == 0),
                 $urandom, (i == 39) ? 1'b1 : 1'($urandom_range(0, 1)));
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL lost_requests: got %0d unissued, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_read_write_collision();
    test_reset_mid_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
